// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard controller for a 5-stage in-order pipeline. Generates
//               the stall/flush controls for a load-use interlock, taken
//               branches, data-memory back-pressure and instruction-fetch
//               latency, including dropping a wrong-path fetch that is still
//               in flight when a branch resolves. Stall/flush outputs are
//               combinational; FSM state and performance counters are
//               registered.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic             imem_valid_F,
  input  logic             dmem_busy_M,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_o
);

  localparam logic [1:0] S_RUN       = 2'd0;
  localparam logic [1:0] S_WAIT_IMEM = 2'd1;
  localparam logic [1:0] S_WAIT_DMEM = 2'd2;
  localparam logic [1:0] S_DROP      = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             load_use;

  // A load whose destination feeds the Decode instruction; x0 never hazards.
  assign load_use = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // State register; reset discards any pending drop or memory wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection, highest-priority event first.
  always_comb begin
    state_d = S_RUN;
    if (dmem_busy_M) begin
      // A pending wrong-path drop must survive a memory freeze.
      state_d = (state_q == S_DROP) ? S_DROP : S_WAIT_DMEM;
    end else if (PCSrcE) begin
      // A fetch still in flight at branch resolution belongs to the wrong path.
      state_d = imem_valid_F ? S_RUN : S_DROP;
    end else if (state_q == S_DROP) begin
      state_d = imem_valid_F ? S_RUN : S_DROP;
    end else if (!imem_valid_F) begin
      // Also covers a load-use stall that overlaps an outstanding fetch.
      state_d = S_WAIT_IMEM;
    end else begin
      state_d = S_RUN;
    end
  end

  // Stall/flush controls from current state and inputs (zero-cycle latency).
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (!rst_n) begin
      // Keep bubbles flowing into Decode/Execute while reset is held.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (dmem_busy_M) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (state_q == S_DROP) begin
      // PC already holds the branch target; squash whatever returns.
      StallF = 1'b1;
      FlushD = 1'b1;
    end else if (load_use) begin
      // The ID/EX flush turns the load's successor into a single bubble.
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (!imem_valid_F) begin
      StallF = 1'b1;
      FlushD = 1'b1;
    end
  end

  // Saturating performance counters for stall and Decode-flush cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (FlushD && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Scoreboard bench for pipeline_hazard_ctrl. A wide-counter and
//               a 4-bit-counter instance share one stimulus stream; expected
//               responses come from a behavioural model of the hazard rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Rs1D, Rs2D, RdE;
  logic        MemReadE, PCSrcE, imem_valid_F, dmem_busy_M;

  logic        StallF, StallD, StallE, FlushD, FlushE;
  logic [31:0] stall_cnt, flush_cnt;
  logic [1:0]  state_o;

  logic        StallF4, StallD4, StallE4, FlushD4, FlushE4;
  logic [3:0]  stall_cnt4, flush_cnt4;
  logic [1:0]  state_o4;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .imem_valid_F(imem_valid_F),
    .dmem_busy_M(dmem_busy_M), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_o(state_o)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .imem_valid_F(imem_valid_F),
    .dmem_busy_M(dmem_busy_M), .StallF(StallF4), .StallD(StallD4),
    .StallE(StallE4), .FlushD(FlushD4), .FlushE(FlushE4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .state_o(state_o4)
  );

  typedef struct {
    logic [4:0] ctl;   // {StallF, StallD, StallE, FlushD, FlushE}
    int         st;
    int         sc;
    int         fc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: plain bookkeeping of mode and event counts.
  int   m_state = 0;   // 0 run, 1 waiting fetch, 2 waiting dmem, 3 dropping
  int   m_stall = 0;
  int   m_flush = 0;

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Apply one cycle of inputs and queue the response the rules demand.
  task automatic step(input bit r, input bit pc, input bit bz, input bit v,
                      input bit mr, input int rd, input int r1, input int r2);
    exp_t e;
    bit   haz, sF, sD, sE, fD, fE;
    int   nx;
    @(posedge clk);
    #1;
    rst_n = r; PCSrcE = pc; dmem_busy_M = bz; imem_valid_F = v;
    MemReadE = mr; RdE = 5'(rd); Rs1D = 5'(r1); Rs2D = 5'(r2);
    haz = mr && (rd != 0) && ((rd == r1) || (rd == r2));
    {sF, sD, sE, fD, fE} = 5'b0;
    nx = 0;
    if (!r) begin
      fD = 1; fE = 1; nx = 0;
    end else if (bz) begin
      sF = 1; sD = 1; sE = 1;
      nx = (m_state == 3) ? 3 : 2;
    end else if (pc) begin
      fD = 1; fE = 1;
      nx = v ? 0 : 3;
    end else if (m_state == 3) begin
      sF = 1; fD = 1;
      nx = v ? 0 : 3;
    end else if (haz) begin
      sF = 1; sD = 1; fE = 1;
      nx = v ? 0 : 1;
    end else if (!v) begin
      sF = 1; fD = 1; nx = 1;
    end else begin
      nx = 0;
    end
    e.ctl = {sF, sD, sE, fD, fE};
    e.st  = m_state;
    e.sc  = m_stall;
    e.fc  = m_flush;
    q.push_back(e);
    if (!r) begin
      m_state = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_state = nx;
      m_stall += int'(sF);
      m_flush += int'(fD);
    end
  endtask

  // Idle, hazard-free cycle with a fetch response available.
  task automatic idle();
    step(1, 0, 0, 1, 0, 0, 1, 2);
  endtask

  // Monitor: every cycle the DUT presents controls, compare against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ctl",      int'({StallF, StallD, StallE, FlushD, FlushE}), int'(e.ctl));
      chk("ctl_w4",   int'({StallF4, StallD4, StallE4, FlushD4, FlushE4}), int'(e.ctl));
      chk("state",    int'(state_o), e.st);
      chk("state_w4", int'(state_o4), e.st);
      chk("stall_cnt", int'(stall_cnt), e.sc);
      chk("flush_cnt", int'(flush_cnt), e.fc);
      chk("stall_cnt_w4", int'(stall_cnt4), sat4(e.sc));
      chk("flush_cnt_w4", int'(flush_cnt4), sat4(e.fc));
    end
  end

  initial begin
    rst_n = 1'b0; PCSrcE = 1'b0; dmem_busy_M = 1'b0; imem_valid_F = 1'b1;
    MemReadE = 1'b0; RdE = '0; Rs1D = '0; Rs2D = '0;
    repeat (2) @(posedge clk);

    // Reset cycle with noisy inputs, then normal flow.
    step(0, 1, 1, 0, 1, 5, 5, 5);
    idle();

    // Load-use on Rs2: one bubble, then the load has moved on.
    step(1, 0, 0, 1, 1, 5, 7, 5);
    idle();

    // Load to x0 never interlocks.
    step(1, 0, 0, 1, 1, 0, 0, 3);

    // Branch while fetch pending: drop the in-flight response.
    step(1, 1, 0, 0, 0, 0, 1, 2);
    step(1, 0, 0, 0, 0, 0, 1, 2);
    step(1, 0, 0, 1, 0, 0, 1, 2);
    idle();

    // Dmem freeze with branch held: three frozen cycles, then one flush.
    step(1, 1, 1, 1, 0, 0, 1, 2);
    step(1, 1, 1, 1, 0, 0, 1, 2);
    step(1, 1, 1, 1, 0, 0, 1, 2);
    step(1, 1, 0, 1, 0, 0, 1, 2);
    idle();

    // Freeze while dropping keeps the drop pending.
    step(1, 1, 0, 0, 0, 0, 1, 2);
    step(1, 0, 1, 1, 0, 0, 1, 2);
    step(1, 0, 0, 1, 0, 0, 1, 2);
    idle();

    // Saturation of the narrow counters: 20 fetch-stall cycles from reset.
    step(0, 0, 0, 1, 0, 0, 1, 2);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0, 1, 2);
    idle();

    // Reset out of DROP discards the drop.
    step(1, 1, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 1, 2);
    idle();
    idle();

    // Randomized traffic with a small register pool to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) >= 2,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 40,
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of each performance counter.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 Port Rs1D / Rs2D, input, 5 each: source register indices of the instruction in Decode.
REQ-005 Port RdE, input, 5: destination register of the instruction in Execute.
REQ-006 Port MemReadE, input, 1: Execute instruction is a load.
REQ-007 Port PCSrcE, input, 1: taken branch or jump resolved in Execute; PC loads the target.
REQ-008 Port imem_valid_F, input, 1: instruction-memory response valid this cycle; one request outstanding at most.
REQ-009 Port dmem_busy_M, input, 1: data memory has not completed the Memory-stage access.
REQ-010 Ports StallF, StallD, StallE, output, 1 each: hold PC, IF/ID, ID/EX respectively (IF/ID en = ~StallD).
REQ-011 Ports FlushD, FlushE, output, 1 each: clear IF/ID and ID/EX to a bubble (IF/ID clr = FlushD).
REQ-012 Ports stall_cnt, flush_cnt, output, CNT_W each: performance counters.
REQ-013 Port state_o, output, 2: current FSM state encoding, for debug.

Function
REQ-014 The FSM SHALL have states RUN=0, WAIT_IMEM=1, WAIT_DMEM=2, DROP=3.
REQ-015 Stall/flush outputs SHALL be combinational from current state and inputs (zero-cycle latency); state and counters SHALL be registered.
REQ-016 Load-use hazard SHALL be defined as MemReadE & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
REQ-017 Priority 1, dmem_busy_M=1: StallF=StallD=StallE=1, FlushD=FlushE=0; next state WAIT_DMEM, except from DROP the state SHALL stay DROP.
REQ-018 Priority 2, PCSrcE=1 (dmem idle): FlushD=FlushE=1, StallF=StallD=StallE=0.
REQ-019 If PCSrcE=1 while imem_valid_F=0, the in-flight fetch is wrong-path; next state SHALL be DROP; otherwise next state RUN.
REQ-020 Priority 3, state DROP and imem_valid_F=1: FlushD=1, StallF=1 (PC retains target for refetch), others 0; next state RUN.
REQ-021 In DROP with imem_valid_F=0 and no higher-priority event: StallF=1, FlushD=1; state stays DROP.
REQ-022 Priority 4, load-use hazard: StallF=StallD=1, FlushE=1, StallE=0, FlushD=0; exactly one bubble per hazard occurrence.
REQ-023 Priority 5, imem_valid_F=0: StallF=1, FlushD=1 (bubble into Decode), StallD=0; next state WAIT_IMEM.
REQ-024 Otherwise all stall/flush outputs SHALL be 0 and next state RUN.
REQ-025 WAIT_DMEM SHALL return to RUN in the first cycle dmem_busy_M=0, with outputs that cycle per priorities 2-5.
REQ-026 A PCSrcE held high during dmem_busy_M SHALL take effect only in the first non-busy cycle, and only once.
REQ-027 stall_cnt SHALL increment by 1 in every cycle StallF=1; flush_cnt SHALL increment by 1 in every cycle FlushD=1.
REQ-028 Counters SHALL saturate at all-ones and not wrap.
REQ-029 FlushD and StallD SHALL never be 1 in the same cycle; likewise FlushE and StallE.

Reset
REQ-030 While rst_n=0 at a clock edge: state <= RUN, stall_cnt <= 0, flush_cnt <= 0.
REQ-031 During the reset cycle, outputs SHALL be StallF=StallD=StallE=0, FlushD=FlushE=1, independent of other inputs.
REQ-032 Reset asserted in any state, including DROP or WAIT_DMEM, SHALL discard the pending drop or stall without further effect.

Verification
REQ-033 Load-use: MemReadE=1, RdE=5, Rs2D=5, imem_valid_F=1 -> one cycle with StallF=StallD=FlushE=1; stall_cnt +1.
REQ-034 RdE=0 case: MemReadE=1, RdE=0, Rs1D=0 -> all stall/flush outputs 0.
REQ-035 Branch with fetch pending: PCSrcE=1, imem_valid_F=0 -> FlushD=FlushE=1, state DROP; imem_valid_F=1 two cycles later -> FlushD=1, StallF=1, then RUN.
REQ-036 Dmem freeze: dmem_busy_M=1 for 3 cycles with PCSrcE=1 held -> 3 cycles all stalls 1 and no flush, then one cycle FlushD=FlushE=1; stall_cnt +3.
REQ-037 Saturation: CNT_W=4, StallF held 20 cycles from reset -> stall_cnt stays 15.
REQ-038 Reset from DROP: rst_n=0 for one cycle -> state_o=0 and counters 0; next imem_valid_F=1 is not dropped.
